// File: rtl/ysyx_23060203_read_arbiter.sv
// ysyx_23060203_read_arbiter: 2:1 AXI4 read arbiter (IFU=m0, LSU=m1), one transaction in flight,
// grant held from AR acceptance to the rlast beat, sticky burst-length error.
module ysyx_23060203_read_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ID_W       = 4,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [ID_W-1:0]   m0_arid,
    input  logic [7:0]        m0_arlen,
    input  logic [2:0]        m0_arsize,
    input  logic [1:0]        m0_arburst,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic [ID_W-1:0]   m0_rid,
    output logic              m0_rlast,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [ID_W-1:0]   m1_arid,
    input  logic [7:0]        m1_arlen,
    input  logic [2:0]        m1_arsize,
    input  logic [1:0]        m1_arburst,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic [ID_W-1:0]   m1_rid,
    output logic              m1_rlast,
    output logic              out_arvalid,
    input  logic              out_arready,
    output logic [ADDR_W-1:0] out_araddr,
    output logic [ID_W-1:0]   out_arid,
    output logic [7:0]        out_arlen,
    output logic [2:0]        out_arsize,
    output logic [1:0]        out_arburst,
    input  logic              out_rvalid,
    output logic              out_rready,
    input  logic [DATA_W-1:0] out_rdata,
    input  logic [1:0]        out_rresp,
    input  logic [ID_W-1:0]   out_rid,
    input  logic              out_rlast,
    output logic              len_err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0] state;
    logic       grant;
    logic       last_served;
    logic [7:0] beat_cnt;
    logic [7:0] arlen_q;
    logic       in_addr;
    logic       in_data;
    logic       sel;
    logic       r_hs;

    assign in_addr = state == ADDR;
    assign in_data = state == DATA;
    // Tie: fixed priority favours the LSU, otherwise whoever was not served last.
    assign sel  = (m0_arvalid & m1_arvalid) ? (FIXED_PRIO ? 1'b1 : ~last_served) : m1_arvalid;
    assign r_hs = out_rvalid & out_rready;

    assign out_arvalid = in_addr & (grant ? m1_arvalid : m0_arvalid);
    assign out_araddr  = in_addr ? (grant ? m1_araddr  : m0_araddr)  : '0;
    assign out_arid    = in_addr ? (grant ? m1_arid    : m0_arid)    : '0;
    assign out_arlen   = in_addr ? (grant ? m1_arlen   : m0_arlen)   : '0;
    assign out_arsize  = in_addr ? (grant ? m1_arsize  : m0_arsize)  : '0;
    assign out_arburst = in_addr ? (grant ? m1_arburst : m0_arburst) : '0;
    assign m0_arready  = in_addr & ~grant & out_arready;
    assign m1_arready  = in_addr & grant & out_arready;

    assign out_rready = in_data & (grant ? m1_rready : m0_rready);
    assign m0_rvalid  = in_data & ~grant & out_rvalid;
    assign m1_rvalid  = in_data & grant & out_rvalid;
    assign m0_rdata   = (in_data & ~grant) ? out_rdata : '0;
    assign m0_rresp   = (in_data & ~grant) ? out_rresp : '0;
    assign m0_rid     = (in_data & ~grant) ? out_rid   : '0;
    assign m0_rlast   = in_data & ~grant & out_rlast;
    assign m1_rdata   = (in_data & grant) ? out_rdata : '0;
    assign m1_rresp   = (in_data & grant) ? out_rresp : '0;
    assign m1_rid     = (in_data & grant) ? out_rid   : '0;
    assign m1_rlast   = in_data & grant & out_rlast;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_served <= 1'b1;
            beat_cnt    <= '0;
            arlen_q     <= '0;
            len_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (m0_arvalid | m1_arvalid) begin
                    grant   <= sel;
                    arlen_q <= sel ? m1_arlen : m0_arlen;
                    state   <= ADDR;
                end
                ADDR: if (out_arvalid & out_arready) begin
                    beat_cnt    <= '0;
                    last_served <= grant;
                    state       <= DATA;
                end
                DATA: if (r_hs) begin
                    beat_cnt <= beat_cnt + 8'd1;
                    // Early or late rlast both flag, but only rlast ends the burst.
                    if (out_rlast) begin
                        if (beat_cnt != arlen_q) len_err <= 1'b1;
                        state <= IDLE;
                    end else if (beat_cnt == arlen_q) begin
                        len_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
